// File: rtl/int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// int_ctrl_pkg
// Shared definitions for the prioritised interrupt controller (prio_int_ctrl):
//   - state_e        : INTA handshake state (IDLE / ACK)
//   - REG_IMR/REG_CMD: register select values on a0
//   - EOI_BIT        : command-register bit requesting a non-specific EOI
//   - spurious_ofs() : vector offset returned when INTA finds nothing pending
// -----------------------------------------------------------------------------
package int_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    localparam logic REG_IMR = 1'b0;
    localparam logic REG_CMD = 1'b1;

    localparam int EOI_BIT = 5;

    // A spurious acknowledge answers with the first vector past the last channel.
    function automatic int spurious_ofs(input int num_irq);
        return num_irq;
    endfunction

endpackage

// File: rtl/prio_int_ctrl_prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc
// Priority encoder, lowest set index wins.
// Ports:
//   req   [N-1:0]  request vector
//   idx   [IW-1:0] index of the lowest set bit (0 when none set)
//   valid          at least one request bit set
// -----------------------------------------------------------------------------
module prio_enc #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            idx   = req[i] ? IW'(i) : idx;
            valid = valid | req[i];
        end
    end

endmodule

// File: rtl/prio_int_ctrl.sv
// -----------------------------------------------------------------------------
// prio_int_ctrl
// Prioritised interrupt controller: latches NUM_IRQ request lines, masks and
// prioritises them (channel 0 highest), raises intr, answers INTA with a
// per-channel vector and tracks in-service state until a non-specific EOI.
//
// Ports:
//   clk, resetN          clock, asynchronous active-low reset
//   irq[NUM_IRQ-1:0]     asynchronous request lines, active high
//   intaN                interrupt acknowledge, active low (synchronised)
//   csN, wrN, rdN, a0    register access strobes and register select
//   din[7:0]             write data
//   dout[7:0], dout_en   registered read data and its bus-drive enable
//   vec[7:0], vec_en     interrupt vector and its bus-drive enable
//   intr                 interrupt request to the CPU (registered)
//
// Build option:
//   PRIO_INT_CTRL_LEVEL_TRIG_EN  when defined, IRR follows the synchronised
//                                irq level each clock instead of latching edges.
// -----------------------------------------------------------------------------
module prio_int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ     = 8,
    parameter logic [7:0]  VEC_BASE    = 8'h10,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               intaN,
    input  logic               csN,
    input  logic               wrN,
    input  logic               rdN,
    input  logic               a0,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               dout_en,
    output logic [7:0]         vec,
    output logic               vec_en,
    output logic               intr
);

    localparam int                 IW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [NUM_IRQ-1:0] ONE_BIT = NUM_IRQ'(1);

    // Synchronisers and edge-detect history
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] irq_sync_q, irq_sync_d;
    logic [NUM_IRQ-1:0]                  irq_prev_q, irq_prev_d;
    logic [SYNC_STAGES-1:0]              ack_sync_q, ack_sync_d;
    logic [SYNC_STAGES-1:0]              wr_sync_q,  wr_sync_d;
    logic                                wr_prev_q,  wr_prev_d;

    // Architectural state
    logic [NUM_IRQ-1:0] irr_q, irr_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [NUM_IRQ-1:0] imr_q, imr_d;
    state_e             state_q, state_d;
    logic [7:0]         vec_q, vec_d;
    logic               vec_en_q, vec_en_d;
    logic               intr_q, intr_d;
    logic [7:0]         dout_q, dout_d;

    // Decoded events
    logic [NUM_IRQ-1:0] irq_lvl_s;
    logic [NUM_IRQ-1:0] irq_rise_s;
    logic               ack_lvl_s;
    logic               wr_rise_s;
    logic [NUM_IRQ-1:0] pend_s;
    logic [IW-1:0]      pend_idx_s;
    logic               pend_vld_s;
    logic [IW-1:0]      isr_idx_s;
    logic               isr_vld_s;
    logic               ack_start_s;
    logic               eoi_s;
    logic               imr_wr_s;
    logic [NUM_IRQ-1:0] win_onehot_s;
    logic [NUM_IRQ-1:0] eoi_onehot_s;

    // Shift the raw inputs through the synchroniser chains.
    always_comb begin
        irq_sync_d    = irq_sync_q;
        ack_sync_d    = ack_sync_q;
        wr_sync_d     = wr_sync_q;
        irq_sync_d[0] = irq;
        ack_sync_d[0] = ~intaN;
        wr_sync_d[0]  = ~csN & ~wrN;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            irq_sync_d[i] = irq_sync_q[i-1];
            ack_sync_d[i] = ack_sync_q[i-1];
            wr_sync_d[i]  = wr_sync_q[i-1];
        end
        irq_prev_d = irq_sync_q[SYNC_STAGES-1];
        wr_prev_d  = wr_sync_q[SYNC_STAGES-1];
    end

    // Decode synchronised levels and rising edges.
    always_comb begin
        irq_lvl_s  = irq_sync_q[SYNC_STAGES-1];
        irq_rise_s = irq_lvl_s & ~irq_prev_q;
        ack_lvl_s  = ack_sync_q[SYNC_STAGES-1];
        wr_rise_s  = wr_sync_q[SYNC_STAGES-1] & ~wr_prev_q;
        pend_s     = irr_q & ~imr_q;
        eoi_s      = wr_rise_s && (a0 == REG_CMD) && din[EOI_BIT];
        imr_wr_s   = wr_rise_s && (a0 == REG_IMR);
    end

    prio_enc #(.N(NUM_IRQ), .IW(IW)) u_pend_enc (
        .req   (pend_s),
        .idx   (pend_idx_s),
        .valid (pend_vld_s)
    );

    prio_enc #(.N(NUM_IRQ), .IW(IW)) u_isr_enc (
        .req   (isr_q),
        .idx   (isr_idx_s),
        .valid (isr_vld_s)
    );

    // INTA handshake state machine; the ACK entry cycle latches the winner.
    always_comb begin
        state_d     = state_q;
        ack_start_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (ack_lvl_s) begin
                    state_d     = ACK;
                    ack_start_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (!ack_lvl_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of IRR/ISR/IMR, vector, intr and read data.
    always_comb begin
        win_onehot_s = '0;
        eoi_onehot_s = '0;
        vec_d        = vec_q;
        imr_d        = imr_q;
        dout_d       = 8'h00;

        if (ack_start_s && pend_vld_s) begin
            win_onehot_s = ONE_BIT << pend_idx_s;
            vec_d        = VEC_BASE + 8'(pend_idx_s);
        end else if (ack_start_s) begin
            vec_d = VEC_BASE + 8'(spurious_ofs(NUM_IRQ));
        end else begin
            vec_d = vec_q;
        end

        if (eoi_s && isr_vld_s) begin
            eoi_onehot_s = ONE_BIT << isr_idx_s;
        end else begin
            eoi_onehot_s = '0;
        end

`ifdef PRIO_INT_CTRL_LEVEL_TRIG_EN
        irr_d = irq_lvl_s & ~win_onehot_s;
`else
        // A new edge on the channel being acknowledged keeps its IRR bit set.
        irr_d = (irr_q & ~win_onehot_s) | irq_rise_s;
`endif

        // EOI retires the old highest in-service bit before the new winner lands.
        isr_d = (isr_q & ~eoi_onehot_s) | win_onehot_s;

        if (imr_wr_s) begin
            imr_d = din[NUM_IRQ-1:0];
        end else begin
            imr_d = imr_q;
        end

        vec_en_d = (state_d == ACK);
        intr_d   = (state_d == IDLE) && pend_vld_s &&
                   (!isr_vld_s || (pend_idx_s < isr_idx_s));

        if (a0 == REG_CMD) begin
            dout_d[NUM_IRQ-1:0] = isr_q;
        end else begin
            dout_d[NUM_IRQ-1:0] = imr_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            irq_sync_q <= '0;
            irq_prev_q <= '0;
            ack_sync_q <= '0;
            wr_sync_q  <= '0;
            wr_prev_q  <= 1'b0;
            irr_q      <= '0;
            isr_q      <= '0;
            imr_q      <= '1;
            state_q    <= IDLE;
            vec_q      <= 8'h00;
            vec_en_q   <= 1'b0;
            intr_q     <= 1'b0;
            dout_q     <= 8'h00;
        end else begin
            irq_sync_q <= irq_sync_d;
            irq_prev_q <= irq_prev_d;
            ack_sync_q <= ack_sync_d;
            wr_sync_q  <= wr_sync_d;
            wr_prev_q  <= wr_prev_d;
            irr_q      <= irr_d;
            isr_q      <= isr_d;
            imr_q      <= imr_d;
            state_q    <= state_d;
            vec_q      <= vec_d;
            vec_en_q   <= vec_en_d;
            intr_q     <= intr_d;
            dout_q     <= dout_d;
        end
    end

    assign dout    = dout_q;
    assign dout_en = ~csN & ~rdN;
    assign vec     = vec_q;
    assign vec_en  = vec_en_q;
    assign intr    = intr_q;

endmodule

// File: doc/prio_int_ctrl.md
Name: prio_int_ctrl

Overview:
- Parametrised interrupt controller; next generation of the single-source IRQ latch (7474 flip-flop cleared by intaN) plus fixed-vector 74244 buffer.
- Latches NUM_IRQ request lines, masks and prioritises them, and drives the CPU intr line.
- Answers the INTA cycle with a per-channel vector and tracks in-service state until software issues EOI through an I/O port.
- Sits between the peripherals and latched_cpu. The top owns the tri-state buffers onto d7to0 through the *_en outputs.

Parameters:
- NUM_IRQ, 8, number of request channels (1..8).
- VEC_BASE, 8'h10, vector returned for channel 0; channel k returns VEC_BASE+k.
- SYNC_STAGES, 2, synchroniser depth on the irq inputs (>=2).

Ports:
- clk  input  1  system clock.
- resetN  input  1  asynchronous active-low reset.
- irq  input  NUM_IRQ  asynchronous request lines, active high.
- intaN  input  1  CPU interrupt acknowledge, active low.
- csN  input  1  register chip select from io_dec, active low.
- wrN  input  1  CPU write strobe, active low.
- rdN  input  1  CPU read strobe, active low.
- a0  input  1  register select.
- din  input  8  write data from d7to0.
- dout  output  8  register read data.
- dout_en  output  1  drive dout onto the bus.
- vec  output  8  interrupt vector.
- vec_en  output  1  drive vec onto the bus.
- intr  output  1  interrupt request to CPU.

Behaviour:
- Reset (async, resetN=0):
  - IRR=0, ISR=0, IMR=all ones (all masked), synchronisers=0.
  - intr=0, vec=0, vec_en=0, dout=0, dout_en=0, state=IDLE.
  - Reset during an INTA cycle aborts it; no ISR bit is set.
- Synchronisation: irq passes through SYNC_STAGES flops. A 0->1 transition on a synchronised bit sets IRR[k], giving 3 clk latency from the irq edge to IRR with SYNC_STAGES=2.
- Priority: channel 0 is highest.
  - pend = IRR & ~IMR.
  - intr=1 (registered) when pend != 0 AND the highest pend index is strictly higher priority than the highest ISR index (or ISR=0).
  - intr is forced 0 while state=ACK.
- FSM on the synchronised edge of intaN:
  - IDLE -> ACK when intaN goes low:
    - Latch win = highest pend index; clear IRR[win]; set ISR[win]; vec=VEC_BASE+win.
    - If pend=0 (spurious): vec=VEC_BASE+NUM_IRQ, IRR/ISR unchanged.
    - vec_en=1 on the next clk.
  - ACK -> IDLE when intaN returns high: vec_en=0 on the next clk; vec holds its value.
- Simultaneous events:
  - An irq edge on channel win in the same cycle it is acked: set wins, so IRR[win] stays 1.
  - Edges on other channels are always recorded.
  - A repeat edge on a channel already in IRR is lost (single-bit latch).
- Register writes: take effect once, on the cycle where the synchronised (~csN & ~wrN) rises.
  - a0=0: IMR <= din[NUM_IRQ-1:0].
  - a0=1, din[5]=1: non-specific EOI; clear the highest-priority set ISR bit, no-op if ISR=0.
  - a0=1, din[5]=0: ignored.
- Register reads: while ~csN & ~rdN, dout_en=1 combinationally; dout is registered each clk.
  - a0=0: dout=IMR.
  - a0=1: dout=ISR.
  - Unused upper bits read 0.
  - dout_en=0 when not selected.
- vec arithmetic is 8-bit, modulo 256; VEC_BASE+NUM_IRQ wraps silently.

Optional Feature:
- PRIO_INT_CTRL_LEVEL_TRIG_EN defined: IRR[k] is reloaded every clk from the synchronised irq[k] level; an INTA clear only affects the cycle it happens in.
- Not defined: edge-triggered latching as specified above.

Decomposition:
- Package int_ctrl_pkg holds:
  - State enum IDLE/ACK.
  - Register-select constants REG_IMR=0, REG_CMD=1.
  - EOI bit index 5.
  - Spurious-offset constant.
- Sub-module prio_enc (NUM_IRQ-wide, lowest index wins, outputs index + valid) is instantiated twice: once for pend, once for ISR.

Test Plan:
- Reset: write IMR=8'h00, pulse irq[3] -> intr=1 within 4 clk; INTA low -> vec_en=1, vec=8'h13, ISR=8'h08; INTA high -> intr=0.
- Priority: irq[5] and irq[2] pulse together -> first INTA gives 8'h12. EOI (din=8'h20, a0=1) -> intr re-asserts; second INTA gives 8'h15.
- Nesting: irq[4] in service, irq[6] pends -> intr stays 0. Then irq[1] pulses -> intr=1, vec 8'h11.
- Masking: IMR=8'hFF, irq[0] pulses -> intr=0. Write IMR=8'hFE -> intr=1 (IRR retained).
- Spurious: INTA with pend=0 -> vec=8'h18, ISR unchanged. resetN low mid-ACK -> vec_en=0, ISR=0 immediately.
- Read-back: read a0=0 -> dout=IMR with dout_en=1. Read a0=1 -> dout=ISR.
